data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU memory request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store (driven from MemWrite), 0 = load (MemtoReg path).
REQ-008 SHALL have port req_addr  input  32  byte address (ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  CPU accepts response.
REQ-012 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL accept a request when req_valid && req_ready, capturing req_we, req_addr, req_wdata in internal registers.
REQ-017 SHALL, on accept, go to RESP if LATENCY==1, else to WAIT with latency counter loaded to LATENCY-2.
REQ-018 SHALL, in WAIT, decrement counter each cycle and go to RESP the cycle after counter==0; rsp_valid thus rises exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL flag error when captured addr[1:0]!=0 or addr[31:2] >= DEPTH.
REQ-020 SHALL, for a non-error store, write the memory word addr[log2(DEPTH)+1:2] on the WAIT->RESP (or IDLE->RESP) transition edge; error stores SHALL write nothing.
REQ-021 SHALL, for a non-error load, present the word read at that same edge on rsp_rdata, held stable throughout RESP.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1; on rsp_valid && rsp_ready return to IDLE next cycle.
REQ-023 SHALL ignore req_valid and input changes outside IDLE (no queueing); a request held high through RESP is accepted on the next IDLE cycle.
REQ-024 SHALL support back-to-back: minimum spacing between accepts is LATENCY+1 cycles with rsp_ready tied high.
REQ-025 SHALL make a load following a store to the same word return the stored data.

Reset
REQ-026 SHALL, on reset low, asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured registers=0; req_ready=1 while reset is deasserted in IDLE.
REQ-027 SHALL abort any in-flight request on reset mid-operation: a pending store SHALL NOT be written; no response SHALL follow.
REQ-028 SHALL NOT reset memory contents.

Structure
REQ-029 SHALL place FSM state encoding (2-bit: IDLE=0, WAIT=1, RESP=2) and default LATENCY/DEPTH constants in the shared CPU package.
REQ-030 SHALL use one sub-module, data_ram (synchronous single-port DEPTH x 32, write-enable, registered read), instantiated by data_mem_resp.

Verification
REQ-031 SHALL cover: store addr 0x08 data 0xDEADBEEF, then load 0x08 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-032 SHALL cover: load addr 0x0A -> rsp_err=1, rdata 0; store 0x0A 0x1234 then load 0x08 still returns 0xDEADBEEF.
REQ-033 SHALL cover: load addr 0x100 (DEPTH=64) -> rsp_err=1, rdata 0, no memory change.
REQ-034 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable all 5 cycles, req_ready=0, second req_valid not accepted until handshake.
REQ-035 SHALL cover: store 0x04 0xCAFEF00D, reset pulsed low in WAIT -> all outputs 0 immediately, req_ready=1 after release, later load 0x04 does not return 0xCAFEF00D.
REQ-036 SHALL cover: LATENCY=1 build, rsp_ready tied high, continuous req_valid -> accepts every 2 cycles, each rsp_valid one cycle after accept.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
//   state_e   : responder FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   addr_err  : misaligned / out-of-range check for a byte address
package data_mem_resp_pkg;
  localparam int DATA_W          = 32;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;   // holds LATENCY-2 for LATENCY up to 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // aw = log2(DEPTH); any address bit above the word index means out of range
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/data_mem_resp_if.sv
// CPU <-> data-memory request/response bus.
//   master : CPU side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_*)
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/data_ram.sv
// Synchronous single-port DEPTH x 32 RAM with registered read.
//   clk   : clock
//   en    : access enable (read register updates only when set)
//   we    : write enable (qualified by en)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (pre-write contents on a write)
// Contents are not reset.
module data_ram
  import data_mem_resp_pkg::*;
#(
  parameter int          DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one CPU load/store at a time, answers it
// exactly LATENCY cycles later and holds the response until taken.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : request/response bus (slave side)
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_resp_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              go_resp;
  logic              cur_we, cur_err;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata, ram_rdata;

  // In IDLE the live request feeds the RAM so a LATENCY==1 build can access
  // it on the accepting edge; otherwise the captured request is used.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end
    cur_err = addr_err(cur_addr, AW);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        we_d    = bus.req_we;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        if (LATENCY == 1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 2);
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        go_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM is touched only on the edge entering RESP; its read register then
  // holds the load data for the whole RESP stay. Reset forces IDLE, so an
  // in-flight store never reaches the array.
  data_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (go_resp),
    .we    (go_resp && cur_we && !cur_err),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready = reset && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = bus.rsp_valid && addr_err(addr_q, AW);
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !addr_err(addr_q, AW)) ? ram_rdata : '0;
endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_mem_resp_if bus_a();
  data_mem_resp_if bus_b();

  data_mem_resp u_a (.clk(clk), .reset(reset), .bus(bus_a));
  data_mem_resp #(.LATENCY(1)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one transaction on bus_a with rsp_ready high; checks latency and response
  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"},   32'(lat), 32'd2);
    chk({tag, ".rdata"}, bus_a.rsp_rdata, exp_rd);
    chk({tag, ".err"},   32'(bus_a.rsp_err), 32'(exp_err));
    step();
  endtask

  initial begin
    bus_a.req_valid = 0; bus_a.req_we = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0; bus_a.rsp_ready = 1;
    bus_b.req_valid = 0; bus_b.req_we = 0; bus_b.req_addr = 0; bus_b.req_wdata = 0; bus_b.rsp_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready_low", 32'(bus_a.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.req_ready", 32'(bus_a.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst.rsp_err",   32'(bus_a.rsp_err), 32'd0);
    step();

    // basic store/load
    run("st08", 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    run("ld08", 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    // misaligned
    run("ld0A", 1'b0, 32'h0A, 32'h0, 32'h0, 1'b1);
    run("st0A", 1'b1, 32'h0A, 32'h1234, 32'h0, 1'b1);
    run("ld08b", 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    // out of range (0x100 aliases word 0 if range check were missing)
    run("st00", 1'b1, 32'h00, 32'h11111111, 32'h0, 1'b0);
    run("ld100", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    run("st100", 1'b1, 32'h100, 32'h99, 32'h0, 1'b1);
    run("ld00", 1'b0, 32'h00, 32'h0, 32'h11111111, 1'b0);
    // last in-range word
    run("stFC", 1'b1, 32'hFC, 32'hA5A5A5A5, 32'h0, 1'b0);
    run("ldFC", 1'b0, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0);

    // response stall with a second request held high
    bus_a.rsp_ready = 1'b0;
    bus_a.req_we = 1'b0; bus_a.req_addr = 32'h08; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_addr = 32'h00;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d.valid", i), 32'(bus_a.rsp_valid), 32'd1);
      chk($sformatf("stall%0d.rdata", i), bus_a.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d.req_ready", i), 32'(bus_a.req_ready), 32'd0);
      if (i < 4) step();
    end
    bus_a.rsp_ready = 1'b1;
    step();
    chk("stall.idle_ready", 32'(bus_a.req_ready), 32'd1);
    chk("stall.idle_valid", 32'(bus_a.rsp_valid), 32'd0);
    step();
    bus_a.req_valid = 1'b0;
    chk("stall2.wait_valid", 32'(bus_a.rsp_valid), 32'd0);
    step();
    chk("stall2.valid", 32'(bus_a.rsp_valid), 32'd1);
    chk("stall2.rdata", bus_a.rsp_rdata, 32'h11111111);
    step();

    // reset during WAIT aborts a store
    run("pre04", 1'b1, 32'h04, 32'h55, 32'h0, 1'b0);
    bus_a.req_we = 1'b1; bus_a.req_addr = 32'h04; bus_a.req_wdata = 32'hCAFEF00D; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort.req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("abort.rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("abort.rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("abort.rsp_err",   32'(bus_a.rsp_err), 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("abort.rel_ready", 32'(bus_a.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort.no_rsp%0d", i), 32'(bus_a.rsp_valid), 32'd0);
    end
    run("post04", 1'b0, 32'h04, 32'h0, 32'h55, 1'b0);

    // LATENCY=1 build, continuous requests
    bus_b.req_we = 1'b1; bus_b.req_addr = 32'h10; bus_b.req_wdata = 32'h77; bus_b.req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("l1.k%0d.req_ready", k), 32'(bus_b.req_ready), 32'((k % 2) == 0));
      chk($sformatf("l1.k%0d.rsp_valid", k), 32'(bus_b.rsp_valid), 32'((k % 2) == 1));
      if (k == 5) chk("l1.rdata", bus_b.rsp_rdata, 32'h77);
      if (k == 4) bus_b.req_we = 1'b0;
      step();
    end
    bus_b.req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
